fetch_prefetch_unit: RTL

//   Instruction fetch stage in front of the RISC-V core decode. Owns the fetch PC,

---
 rtl/fetch_prefetch_unit_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 55 +++++
 rtl/fetch_prefetch_unit.sv | 86 ++++++++
 3 files changed

// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared constants and the FIFO entry layout for the instruction fetch stage.
package fetch_prefetch_unit_pkg;
  localparam int          XLEN             = 32;
  localparam int          WORD_BYTES       = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] data;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with flush; flush wins over push and pop in the same cycle.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [W-1:0]               i_wdata,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic [W-1:0]               o_rdata,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push, w_do_pop;

  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: the read side is gated by o_empty downstream.
  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
endmodule

// File: rtl/fetch_prefetch_unit.sv
// Fetch stage: owns the fetch PC, issues credit-limited word reads and buffers
// returned words as {pc, data} pairs; a redirect flushes and drops stale responses.
module fetch_prefetch_unit
  import fetch_prefetch_unit_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            i_clk,
  input  logic            i_rst,
  output logic            o_mem_req_valid,
  input  logic            i_mem_req_ready,
  output logic [XLEN-1:0] o_mem_req_addr,
  input  logic            i_mem_rsp_valid,
  input  logic [XLEN-1:0] i_mem_rsp_data,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_inst_valid,
  input  logic            i_inst_ready,
  output logic [XLEN-1:0] o_inst_data,
  output logic [XLEN-1:0] o_inst_pc
);
  localparam int CW = $clog2(DEPTH+1);

  logic [XLEN-1:0] r_fetch_pc, r_rsp_pc;
  logic [CW-1:0]   r_outstanding, r_drop;
  logic [CW-1:0]   w_count, w_drop_total, w_drop_next;
  logic [CW+1:0]   w_credits_used;
  logic [XLEN-1:0] w_redirect_pc;
  logic            w_empty, w_accept, w_rsp_keep, w_rsp_drop, w_pop;
  fetch_entry_t    w_wr_entry, w_rd_entry;

  // Every in-flight, dropped or buffered word holds a credit, so a response always has a slot.
  assign w_credits_used  = (CW+2)'(w_count) + (CW+2)'(r_outstanding) + (CW+2)'(r_drop);
  assign o_mem_req_valid = i_rst && !i_redirect_valid && (w_credits_used < (CW+2)'(DEPTH));
  assign o_mem_req_addr  = r_fetch_pc;
  assign w_accept        = o_mem_req_valid && i_mem_req_ready;
  assign w_rsp_drop      = i_mem_rsp_valid && (r_drop != '0);
  assign w_rsp_keep      = i_mem_rsp_valid && (r_drop == '0);
  assign w_redirect_pc   = {i_redirect_pc[XLEN-1:2], 2'b00};
  assign w_drop_total    = r_drop + r_outstanding;
  assign w_drop_next     = (i_mem_rsp_valid && (w_drop_total != '0)) ? w_drop_total - 1'b1
                                                                      : w_drop_total;

  assign o_inst_valid = !w_empty;
  assign w_pop        = o_inst_valid && i_inst_ready;
  assign o_inst_pc    = o_inst_valid ? w_rd_entry.pc   : '0;
  assign o_inst_data  = o_inst_valid ? w_rd_entry.data : '0;
  assign w_wr_entry   = '{pc: r_rsp_pc, data: i_mem_rsp_data};

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else if (i_redirect_valid) begin
      r_fetch_pc    <= w_redirect_pc;
      r_rsp_pc      <= w_redirect_pc;
      r_outstanding <= '0;
      r_drop        <= w_drop_next;
    end else begin
      if (w_accept)   r_fetch_pc <= r_fetch_pc + XLEN'(WORD_BYTES);
      // Responses come back in order, so the PC of the next kept word simply counts up.
      if (w_rsp_keep) r_rsp_pc   <= r_rsp_pc + XLEN'(WORD_BYTES);
      if (w_rsp_drop) r_drop     <= r_drop - 1'b1;
      case ({w_accept, w_rsp_keep})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: ;
      endcase
    end
  end

  fetch_fifo #(.DEPTH(DEPTH), .W(2*XLEN)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_rsp_keep),
    .i_wdata (w_wr_entry),
    .i_pop   (w_pop),
    .i_flush (i_redirect_valid),
    .o_rdata (w_rd_entry),
    .o_empty (w_empty),
    .o_count (w_count)
  );
endmodule
